serial_rx: RTL

- Receive-side counterpart of the board-to-board serial link.
- Recovers the source-synchronous serial clock and 1/2/4/8-bit data lanes by oversampling them in the local 200 MHz domain.
- Reassembles DATA_WIDTH-bit words MSB-group first and presents them on a valid/ready stream through a small output buffer.
- Sits at the FPGA pins on the consuming board; feeds the command/data decoders.

---
 rtl/serial_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_rx.sv
// Receive side of the board-to-board serial link: oversamples RX_CLK/RX_DIN in the
// clk_i domain, deserialises MSB-group first and buffers words on a valid/ready stream.
module serial_rx #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SERIAL_MODE  = 2,
    parameter int unsigned IDLE_TIMEOUT = 16,
    parameter int unsigned OUT_DEPTH    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   RX_CLK,
    input  logic [SERIAL_MODE-1:0] RX_DIN,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic [DATA_WIDTH-1:0]  rx_data_o,
    output logic                   rx_overflow_o,
    output logic                   rx_frame_err_o
);

    localparam int unsigned SERIAL_NUM = DATA_WIDTH / SERIAL_MODE;
    localparam int unsigned CNT_W      = $clog2(SERIAL_NUM);
    localparam int unsigned SH_W       = DATA_WIDTH - SERIAL_MODE;
    localparam int unsigned IDLE_W     = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned PTR_W      = $clog2(OUT_DEPTH);
    localparam int unsigned OCC_W      = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;

    // Input synchronisers; clk_s3 also follows clk_s2 through reset so release never fakes an edge
    logic                   clk_s1, clk_s2, clk_s3;
    logic [SERIAL_MODE-1:0] din_s1, din_s2;

    always_ff @(posedge clk_i) begin
        clk_s1 <= RX_CLK;
        clk_s2 <= clk_s1;
        clk_s3 <= clk_s2;
        din_s1 <= RX_DIN;
        din_s2 <= din_s1;
    end

    logic rise_c;
    assign rise_c = clk_s2 & ~clk_s3;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]       sh_q, sh_d;
    logic [IDLE_W-1:0]     idle_q, idle_d;
    logic                  push_q, push_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  frame_err_d;
    logic [DATA_WIDTH-1:0] word_c;

    // Only the groups that still have to move up are kept; the top group leaves with the word
    assign word_c = {sh_q, din_s2};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            sh_q           <= '0;
            idle_q         <= '0;
            push_q         <= 1'b0;
            word_q         <= '0;
            rx_frame_err_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            sh_q           <= sh_d;
            idle_q         <= idle_d;
            push_q         <= push_d;
            word_q         <= word_d;
            rx_frame_err_o <= frame_err_d;
        end
    end

    // Deserialiser and idle-timeout control
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        idle_d      = idle_q;
        push_d      = 1'b0;
        word_d      = word_q;
        frame_err_d = 1'b0;
        if (rise_c) begin
            idle_d = '0;
            sh_d   = word_c[SH_W-1:0];
            if (bit_cnt_q == CNT_W'(SERIAL_NUM - 1)) begin
                push_d    = 1'b1;
                word_d    = word_c;
                bit_cnt_d = '0;
                state_d   = ST_IDLE;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                state_d   = ST_SHIFT;
            end
        end else if (idle_q < IDLE_W'(IDLE_TIMEOUT)) begin
            idle_d = idle_q + IDLE_W'(1);
            // Saturation makes this fire once per idle period
            if ((idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) && (bit_cnt_q != '0)) begin
                bit_cnt_d   = '0;
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
            end
        end
    end

    // Output FIFO, first-word-fall-through with a registered head
    logic [DATA_WIDTH-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]      rd_q, wr_q, rd_d, wr_d;
    logic [OCC_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_d;
    logic                  pop_c, wr_en_c, ovf_set_c, full_c;

    always_comb begin
        full_c    = (cnt_q == OCC_W'(OUT_DEPTH));
        pop_c     = rx_valid_o & rx_ready_i;
        wr_en_c   = push_q & (~full_c | pop_c);
        ovf_set_c = push_q & full_c & ~pop_c;
        rd_d      = rd_q + PTR_W'(pop_c);
        wr_d      = wr_q + PTR_W'(wr_en_c);
        cnt_d     = cnt_q + OCC_W'(wr_en_c) - OCC_W'(pop_c);
        head_d    = rx_data_o;
        if (pop_c) begin
            if (wr_en_c && (rd_d == wr_q)) begin
                head_d = word_q;
            end else begin
                head_d = mem[rd_d];
            end
        end else if ((cnt_q == '0) && wr_en_c) begin
            head_d = word_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem[wr_q] <= word_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_q          <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
            rx_valid_o    <= 1'b0;
            rx_data_o     <= '0;
            rx_overflow_o <= 1'b0;
        end else begin
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            rx_valid_o    <= (cnt_d != '0);
            rx_data_o     <= head_d;
            rx_overflow_o <= rx_overflow_o | ovf_set_c;
        end
    end

endmodule
